// File: rtl/sift_sys_pkg.sv
// Shared system-mode codes, row geometry and the row-sequencer state encoding
// used across the SIFT front-end blocks.
package sift_sys_pkg;

  typedef enum logic [2:0] {
    SYS_IDLE          = 3'd0,
    SYS_GAUSSIAN      = 3'd1,
    SYS_DETECT_FILTER = 3'd2,
    SYS_COMPUTE_MATCH = 3'd3,
    SYS_END           = 3'd4
  } sys_mode_e;

  localparam int SYS_ROW_WIDTH = 5120;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_FETCH = 3'd1,
    RS_PAD   = 3'd2,
    RS_DRAIN = 3'd3,
    RS_DONE  = 3'd4
  } row_seq_state_e;

endpackage

// File: rtl/gaussian_row_sequencer_if.sv
// Handshake/bus bundle between the row sequencer (slave side) and its
// controller, SRAM and line buffer (master side).
interface gaussian_row_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [2:0]        op_mode;
  logic              abort;
  logic              ds_ready;
  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [2:0]        buffer_mode;
  logic              buffer_we;
  logic              fill_zero;
  logic              out_valid;
  logic [ADDR_W-1:0] out_row;
  logic              busy;
  logic              done;

  modport master (
    output start, op_mode, abort, ds_ready,
    input  sram_re, sram_addr, buffer_mode, buffer_we, fill_zero,
    input  out_valid, out_row, busy, done
  );

  modport slave (
    input  start, op_mode, abort, ds_ready,
    output sram_re, sram_addr, buffer_mode, buffer_we, fill_zero,
    output out_valid, out_row, busy, done
  );
endinterface

// File: rtl/gaussian_row_sequencer_push.sv
// row_push_tracker: turns read/pad requests into registered line-buffer pushes,
// counts them and flags when the buffered window is centred on an output row.
module row_push_tracker #(
  parameter int ADDR_W = 9,
  parameter int G_RAD  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_req_i,
  input  logic              pad_req_i,
  input  logic              detect_i,
  input  logic [ADDR_W:0]   total_i,
  output logic              buffer_we_o,
  output logic              fill_zero_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_row_o,
  output logic              final_o
);
  localparam int CW = ADDR_W + 1;

  logic              we_q, fz_q, ov_q, fin_q;
  logic [ADDR_W-1:0] row_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     thresh_s, off_s;
  logic              hit_s;

  // Window geometry: 3-row detect window centres one row back, Gaussian G_RAD back.
  always_comb begin
    thresh_s = CW'(G_RAD);
    off_s    = CW'(G_RAD);
    if (detect_i) begin
      thresh_s = CW'(2);
      off_s    = CW'(1);
    end else begin
      thresh_s = CW'(G_RAD);
      off_s    = CW'(G_RAD);
    end
    hit_s = we_q && (cnt_q >= thresh_s);
  end

  // Push strobes, push counter and registered window flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      fz_q  <= 1'b0;
      ov_q  <= 1'b0;
      fin_q <= 1'b0;
      row_q <= {ADDR_W{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else if (clear_i) begin
      we_q  <= 1'b0;
      fz_q  <= 1'b0;
      ov_q  <= 1'b0;
      fin_q <= 1'b0;
      row_q <= {ADDR_W{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      we_q  <= push_req_i;
      fz_q  <= pad_req_i;
      if (we_q) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= cnt_q;
      end
      ov_q  <= hit_s;
      row_q <= hit_s ? ADDR_W'(cnt_q - off_s) : {ADDR_W{1'b0}};
      fin_q <= we_q && (cnt_q == (total_i - CW'(1)));
    end
  end

  assign buffer_we_o = we_q;
  assign fill_zero_o = fz_q;
  assign out_valid_o = ov_q;
  assign out_row_o   = row_q;
  assign final_o     = fin_q;

endmodule

// File: rtl/gaussian_row_sequencer.sv
// Row sequencer feeding the 10-row line buffer: FSM and SRAM read counter.
// Optional Gaussian bottom padding is compiled in with ROW_SEQ_PAD_EN.
module gaussian_row_sequencer
  import sift_sys_pkg::*;
#(
  parameter int IMG_ROWS = 480,
  parameter int ADDR_W   = 9,
  parameter int G_RAD    = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  gaussian_row_sequencer_if.slave bus_if
);
  localparam int            CW       = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_RD  = CW'(IMG_ROWS - 1);
  localparam logic [CW-1:0] LAST_PAD = CW'(IMG_ROWS + G_RAD - 1);

  row_seq_state_e state_q, state_d, fsm_nxt_s;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]     op_q, op_d, mode_q;
  logic           busy_q, done_q;
  logic           sram_re_s, pad_req_s, pad_sel_s, final_s, clear_s;
  logic [CW-1:0]  total_s;

`ifdef ROW_SEQ_PAD_EN
  assign pad_sel_s = (op_q == SYS_GAUSSIAN);
  assign pad_req_s = (state_q == RS_PAD) && bus_if.ds_ready;
  assign total_s   = pad_sel_s ? CW'(IMG_ROWS + G_RAD) : CW'(IMG_ROWS);
`else
  assign pad_sel_s = 1'b0;
  assign pad_req_s = 1'b0;
  assign total_s   = CW'(IMG_ROWS);
`endif

  assign sram_re_s = (state_q == RS_FETCH) && bus_if.ds_ready;
  assign clear_s   = bus_if.abort || (state_q == RS_IDLE);

  // Next-state and read/pad counter; abort overrides every transition.
  always_comb begin
    fsm_nxt_s = state_q;
    rd_cnt_d  = rd_cnt_q;
    op_d      = op_q;
    case (state_q)
      RS_IDLE: begin
        rd_cnt_d = {CW{1'b0}};
        if (bus_if.start && ((bus_if.op_mode == SYS_GAUSSIAN) ||
                             (bus_if.op_mode == SYS_DETECT_FILTER))) begin
          fsm_nxt_s = RS_FETCH;
          op_d      = bus_if.op_mode;
        end else begin
          fsm_nxt_s = RS_IDLE;
        end
      end
      RS_FETCH: begin
        if (sram_re_s) begin
          rd_cnt_d  = rd_cnt_q + CW'(1);
          fsm_nxt_s = (rd_cnt_q == LAST_RD) ? (pad_sel_s ? RS_PAD : RS_DRAIN) : RS_FETCH;
        end else begin
          fsm_nxt_s = RS_FETCH;
        end
      end
      RS_PAD: begin
        if (pad_req_s) begin
          rd_cnt_d  = rd_cnt_q + CW'(1);
          fsm_nxt_s = (rd_cnt_q == LAST_PAD) ? RS_DRAIN : RS_PAD;
        end else begin
          fsm_nxt_s = RS_PAD;
        end
      end
      RS_DRAIN: begin
        if (final_s) begin
          fsm_nxt_s = RS_DONE;
        end else begin
          fsm_nxt_s = RS_DRAIN;
        end
      end
      RS_DONE:  fsm_nxt_s = RS_IDLE;
      default:  fsm_nxt_s = RS_IDLE;
    endcase
    if (bus_if.abort) begin
      state_d = RS_IDLE;
    end else begin
      state_d = fsm_nxt_s;
    end
  end

  // State register with registered busy/done/buffer_mode derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RS_IDLE;
      rd_cnt_q <= {CW{1'b0}};
      op_q     <= SYS_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= SYS_IDLE;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      op_q     <= op_d;
      busy_q   <= (state_d != RS_IDLE);
      done_q   <= (state_d == RS_DONE);
      mode_q   <= ((state_d == RS_FETCH) || (state_d == RS_PAD) || (state_d == RS_DRAIN))
                  ? op_d : SYS_IDLE;
    end
  end

  row_push_tracker #(
    .ADDR_W (ADDR_W),
    .G_RAD  (G_RAD)
  ) u_push (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_s),
    .push_req_i  (sram_re_s || pad_req_s),
    .pad_req_i   (pad_req_s),
    .detect_i    (op_q == SYS_DETECT_FILTER),
    .total_i     (total_s),
    .buffer_we_o (bus_if.buffer_we),
    .fill_zero_o (bus_if.fill_zero),
    .out_valid_o (bus_if.out_valid),
    .out_row_o   (bus_if.out_row),
    .final_o     (final_s)
  );

  assign bus_if.sram_re     = sram_re_s;
  assign bus_if.sram_addr   = sram_re_s ? rd_cnt_q[ADDR_W-1:0] : {ADDR_W{1'b0}};
  assign bus_if.buffer_mode = mode_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;

endmodule

// File: tb/tb_gaussian_row_sequencer.sv
// Self-checking bench for gaussian_row_sequencer; expectations come from a
// request-list model driven by the per-cycle ds_ready pattern.
module tb_gaussian_row_sequencer;
  localparam int IMG  = 8;
  localparam int AW   = 4;
  localparam int GR   = 3;
  localparam int MAXC = 128;
`ifdef ROW_SEQ_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gaussian_row_sequencer_if #(.ADDR_W(AW)) bus();

  gaussian_row_sequencer #(.IMG_ROWS(IMG), .ADDR_W(AW), .G_RAD(GR)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int total_cmp = 0;
  int bad = 0;
  int obs_done;
  int exp_done;

  bit         a_start[MAXC];
  logic [2:0] a_op[MAXC];
  bit         a_abort[MAXC];
  bit         a_rdy[MAXC];
  bit         e_re[MAXC], e_we[MAXC], e_fz[MAXC], e_ov[MAXC];
  bit         e_busy[MAXC], e_done[MAXC], skip_ov[MAXC];
  int         e_addr[MAXC], e_row[MAXC];
  logic [2:0] e_mode[MAXC];

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      a_start[c] = 1'b0; a_op[c] = 3'd0; a_abort[c] = 1'b0; a_rdy[c] = 1'b1;
      e_re[c] = 1'b0; e_we[c] = 1'b0; e_fz[c] = 1'b0; e_ov[c] = 1'b0;
      e_busy[c] = 1'b0; e_done[c] = 1'b0; skip_ov[c] = 1'b0;
      e_addr[c] = 0; e_row[c] = 0; e_mode[c] = 3'd0;
    end
  endtask

  // Requests are served on ds_ready cycles after start: IMG reads, then pads.
  task automatic build_model(input int s, input logic [2:0] op);
    int n_tot, req, last_c;
    n_tot  = IMG + (((op == 3'd1) && PAD_EN) ? GR : 0);
    req    = 0;
    last_c = s;
    for (int c = s + 1; (c < MAXC - 3) && (req < n_tot); c++) begin
      if (a_rdy[c]) begin
        if (req < IMG) begin
          e_re[c] = 1'b1; e_addr[c] = req;
        end
        e_we[c+1] = 1'b1;
        e_fz[c+1] = (req >= IMG);
        if ((op == 3'd1) && (req >= GR)) begin
          e_ov[c+2] = 1'b1; e_row[c+2] = req - GR;
        end else if ((op == 3'd2) && (req >= 2)) begin
          e_ov[c+2] = 1'b1; e_row[c+2] = req - 1;
        end
        req++;
        last_c = c;
      end
    end
    exp_done = last_c + 3;
    for (int c = s + 1; c <= exp_done; c++) begin
      e_busy[c] = 1'b1;
      e_mode[c] = (c < exp_done) ? op : 3'd0;
    end
    e_done[exp_done] = 1'b1;
  endtask

  task automatic run_check(input int ncyc, input string tag);
    obs_done = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start = a_start[c]; bus.op_mode = a_op[c];
      bus.abort = a_abort[c]; bus.ds_ready = a_rdy[c];
      #3;
      total_cmp++;
      if (bus.sram_re !== e_re[c]) begin
        bad++; $display("FAIL %s sram_re cyc=%0d got=%b want=%b", tag, c, bus.sram_re, e_re[c]);
      end
      if (e_re[c]) begin
        total_cmp++;
        if (bus.sram_addr !== AW'(e_addr[c])) begin
          bad++; $display("FAIL %s sram_addr cyc=%0d got=%0d want=%0d", tag, c, bus.sram_addr, e_addr[c]);
        end
      end
      total_cmp++;
      if ({bus.buffer_we, bus.fill_zero} !== {e_we[c], e_fz[c]}) begin
        bad++; $display("FAIL %s we/fz cyc=%0d got=%b%b want=%b%b", tag, c,
                        bus.buffer_we, bus.fill_zero, e_we[c], e_fz[c]);
      end
      if (!skip_ov[c]) begin
        total_cmp++;
        if (bus.out_valid !== e_ov[c]) begin
          bad++; $display("FAIL %s out_valid cyc=%0d got=%b want=%b", tag, c, bus.out_valid, e_ov[c]);
        end
      end
      if (e_ov[c]) begin
        total_cmp++;
        if (bus.out_row !== AW'(e_row[c])) begin
          bad++; $display("FAIL %s out_row cyc=%0d got=%0d want=%0d", tag, c, bus.out_row, e_row[c]);
        end
      end
      total_cmp++;
      if ({bus.busy, bus.done, bus.buffer_mode} !== {e_busy[c], e_done[c], e_mode[c]}) begin
        bad++; $display("FAIL %s busy/done/mode cyc=%0d got=%b/%b/%0d want=%b/%b/%0d", tag, c,
                        bus.busy, bus.done, bus.buffer_mode, e_busy[c], e_done[c], e_mode[c]);
      end
      if ((bus.done === 1'b1) && (obs_done < 0)) obs_done = c;
    end
  endtask

  task automatic test_reset();
    #3;
    total_cmp++;
    if ({bus.sram_re, bus.sram_addr, bus.buffer_we, bus.fill_zero, bus.out_valid,
         bus.out_row, bus.busy, bus.done, bus.buffer_mode} !== 19'd0) begin
      bad++; $display("FAIL reset outputs got=%b want=0", {bus.sram_re, bus.sram_addr, bus.buffer_we,
                      bus.fill_zero, bus.out_valid, bus.out_row, bus.busy, bus.done, bus.buffer_mode});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_gauss_nostall();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd1;
    build_model(0, 3'd1);
    run_check(exp_done + 4, "gauss");
    total_cmp++;
    if (obs_done !== (PAD_EN ? 14 : 11)) begin
      bad++; $display("FAIL gauss_done_cycle got=%0d want=%0d", obs_done, PAD_EN ? 14 : 11);
    end
  endtask

  task automatic test_detect();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd2;
    build_model(0, 3'd2);
    run_check(exp_done + 4, "detect");
    total_cmp++;
    if (obs_done !== 11) begin
      bad++; $display("FAIL detect_done_cycle got=%0d want=11", obs_done);
    end
  endtask

  task automatic test_stall();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd1;
    for (int c = 4; c <= 6; c++) a_rdy[c] = 1'b0;
    build_model(0, 3'd1);
    run_check(exp_done + 4, "stall");
    total_cmp++;
    if (obs_done !== (PAD_EN ? 17 : 14)) begin
      bad++; $display("FAIL stall_done_cycle got=%0d want=%0d", obs_done, PAD_EN ? 17 : 14);
    end
  endtask

  task automatic test_abort();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd1;
    build_model(0, 3'd1);
    a_abort[5] = 1'b1;
    for (int c = 6; c < MAXC; c++) begin
      e_re[c] = 1'b0; e_we[c] = 1'b0; e_fz[c] = 1'b0; e_ov[c] = 1'b0;
      e_busy[c] = 1'b0; e_done[c] = 1'b0; e_mode[c] = 3'd0;
    end
    skip_ov[6] = 1'b1;
    run_check(20, "abort");
  endtask

  task automatic test_illegal();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd3;
    a_start[2] = 1'b1; a_op[2] = 3'd1; a_abort[2] = 1'b1;
    a_start[4] = 1'b1; a_op[4] = 3'd0;
    run_check(10, "illegal");
  endtask

  task automatic test_restart_busy();
    clear_stim();
    for (int c = 0; c < MAXC; c++) a_op[c] = 3'd2;
    a_start[0] = 1'b1;
    a_start[4] = 1'b1; a_op[4] = 3'd1;
    a_start[9] = 1'b1;
    build_model(0, 3'd2);
    run_check(exp_done + 3, "restart_busy");
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int p = 0; p < 6; p++) begin
      clear_stim();
      op = 3'($urandom_range(1, 2));
      a_start[0] = 1'b1; a_op[0] = op;
      for (int c = 1; c < 40; c++) a_rdy[c] = ($urandom_range(0, 3) != 0);
      build_model(0, op);
      run_check(exp_done + 3, "random");
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    a_start[0] = 1'b1; a_op[0] = 3'd1;
    build_model(0, 3'd1);
    run_check(4, "reset_mid_pre");
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.ds_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total_cmp++;
    if ({bus.sram_re, bus.sram_addr, bus.buffer_we, bus.fill_zero, bus.out_valid,
         bus.out_row, bus.busy, bus.done, bus.buffer_mode} !== 19'd0) begin
      bad++; $display("FAIL reset_mid outputs got=%b want=0", {bus.sram_re, bus.sram_addr, bus.buffer_we,
                      bus.fill_zero, bus.out_valid, bus.out_row, bus.busy, bus.done, bus.buffer_mode});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_stim();
    run_check(8, "reset_mid_post");
  endtask

  initial begin
    bus.start = 1'b0; bus.op_mode = 3'd0; bus.abort = 1'b0; bus.ds_ready = 1'b1;
    test_reset();
    test_gauss_nostall();
    test_detect();
    test_stall();
    test_abort();
    test_illegal();
    test_restart_busy();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cmp, bad);
    $finish;
  end

endmodule

// File: doc/gaussian_row_sequencer.md
# gaussian_row_sequencer

Control stage directly upstream of the 10-row line buffer. Issues row reads to the image SRAM, drives `buffer_mode`, `buffer_we` and `fill_zero` so the buffer shifts one row per push, and injects trailing zero rows for Gaussian bottom padding. Flags when the buffered window is centred on a valid output row, so the downstream blur/DoG datapath knows when to consume.

## Interface
- `IMG_ROWS`, 480: image height in rows.
- `ADDR_W`, 9: SRAM row-address width; must satisfy 2^ADDR_W ≥ IMG_ROWS.
- `G_RAD`, 3: Gaussian vertical radius, giving a 7-row window.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a frame pass. Ignored unless the block is IDLE.
- `op_mode` in 3: `SYS_GAUSSIAN` (1) or `SYS_DETECT_FILTER` (2). Sampled on `start`.
- `abort` in 1: synchronous cancel.
- `ds_ready` in 1: downstream datapath can accept a new window.
- `sram_re` out 1: row read strobe.
- `sram_addr` out ADDR_W: row index being read.
- `buffer_mode` out 3: mode to the line buffer.
- `buffer_we` out 1: shift/push strobe to the line buffer.
- `fill_zero` out 1: push a zero row into slot 0.
- `out_valid` out 1: window centred on `out_row` this cycle.
- `out_row` out ADDR_W: centre row index of the window.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the pass completes.

## Operation
- **States:**
  - IDLE → FETCH on `start` when `op_mode` ∈ {1,2}. Any other mode value is ignored and the block stays in IDLE.
  - FETCH → PAD after the read of row IMG_ROWS-1 is issued, in Gaussian mode with padding compiled in.
  - FETCH → DRAIN otherwise.
  - PAD → DRAIN after G_RAD zero pushes.
  - DRAIN → DONE after the final push and its `out_valid`.
  - DONE → IDLE after one cycle.
- **`buffer_mode`:** `SYS_IDLE` (0) in IDLE and DONE; otherwise the latched `op_mode`. Because the buffer clears while in `SYS_IDLE`, every pass starts from all-zero rows, which supplies the top padding.
- **FETCH:** a read (`sram_re`=1, `sram_addr`=r) is issued only in cycles where `ds_ready`=1. Reads go in order r = 0..IMG_ROWS-1, at most one per cycle.
- **Push:** each read produces exactly one push one cycle later (`buffer_we`=1). The push is not gated by `ds_ready`.
- **PAD:** in cycles where `ds_ready`=1, assert `fill_zero`=1 and `buffer_we`=1 together, with no SRAM read. Both strobes are required so the upper slots still shift.
- **Gaussian windows:** after push k (0-based) with k ≥ G_RAD, assert `out_valid` with `out_row`=k-G_RAD. Total pushes = IMG_ROWS+G_RAD, so output rows run 0..IMG_ROWS-1.
- **Detect windows:** the window is 3 rows. After push k with k ≥ 2, assert `out_valid` with `out_row`=k-1. Total pushes = IMG_ROWS, so output rows run 1..IMG_ROWS-2; border rows are never flagged.
- **`abort`:** in any state, the next state is IDLE. A push still in flight is suppressed (`buffer_we` stays 0). `done` is not pulsed.
- **Counters:** the read counter and the push counter are ADDR_W+1 bits wide. They never wrap, because all terminal comparisons are equality checks against IMG_ROWS-1 or the pad count.
- **`start` while busy:** ignored. `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.

## Timing
- Reset values: all outputs 0. `buffer_mode`=`SYS_IDLE`. State IDLE, counters 0.
- `start` at cycle t: the first `sram_re` appears at t+1, provided `ds_ready`=1.
- SRAM read latency is fixed at 1: a read at cycle c gives `buffer_we` at c+1.
- `out_valid` is registered and follows its push by one cycle.
- Throughput: one row per cycle while `ds_ready`=1.
  - Gaussian pass, no stalls: `done` at t+IMG_ROWS+G_RAD+3.
  - Detect pass, no stalls: `done` at t+IMG_ROWS+3.
- Asynchronous reset mid-pass: all outputs drop to reset values immediately. Nothing resumes.

## Configuration
- `ROW_SEQ_PAD_EN` defined: Gaussian mode runs the PAD state and emits output rows 0..IMG_ROWS-1.
- `ROW_SEQ_PAD_EN` undefined: there is no PAD state and `fill_zero` is tied to 0. A Gaussian pass goes FETCH → DRAIN and emits output rows 0..IMG_ROWS-1-G_RAD.
- Detect mode behaves the same either way.

## Structure
- Shared package `sift_sys_pkg`:
  - `SYS_IDLE`, `SYS_GAUSSIAN`, `SYS_DETECT_FILTER`, `SYS_COMPUTE_MATCH`, `SYS_END`.
  - Row width constant 5120.
  - The state-encoding typedef.
- One sub-module, `row_push_tracker`. It owns the push counter and the registered `buffer_we` and `fill_zero`, and generates `out_valid`/`out_row`. The top level keeps the FSM and the read counter.

## Test plan
1. **Gaussian pass, no stalls.** IMG_ROWS=8, G_RAD=3, padding compiled in, `ds_ready`=1, `start` at t=0.
   - Reads at addresses 0..7 in cycles 1..8.
   - `fill_zero` pushes in cycles 10..12.
   - `out_valid` with `out_row` 0..7.
   - `done` at cycle 14.
2. **Detect pass.** IMG_ROWS=8, `op_mode`=2.
   - 8 pushes, no `fill_zero`.
   - `out_row` runs 1..6, six `out_valid` pulses in total.
   - `buffer_mode`=2 throughout the pass, 0 after `done`.
3. **Stall.** Drop `ds_ready` for 3 cycles after read 2.
   - No `sram_re` during the stall.
   - The push for read 2 still occurs.
   - Sequence resumes at address 3; `done` is delayed by exactly 3 cycles.
4. **Abort.** Assert `abort` in the same cycle as read 4.
   - No `buffer_we` the next cycle.
   - `busy`=0 and `buffer_mode`=0.
   - No `done` pulse.
5. **Illegal start, restart and reset.**
   - `start` with `op_mode`=3: the block stays IDLE.
   - `start` while busy: no effect on the running pass.
   - `rst_n` low mid-FETCH: all outputs 0 immediately.
6. **Padding compiled out.** `ROW_SEQ_PAD_EN` undefined, Gaussian mode, IMG_ROWS=8.
   - `fill_zero` never asserted.
   - `out_row` runs 0..4.
   - `done` at cycle 11.
